// File: rtl/truth_table_sweeper_pkg.sv
// tt_sweep_pkg: shared types and helpers for the truth-table sweeper.
//   state_t        sweep FSM states
//   TT_ONE_HOT_3   truth-table code of the 3-input exactly-one-hot gate
//   idx_to_inputs  combination index -> {in1,in2,in3}
package tt_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [7:0] TT_ONE_HOT_3 = 8'h16;

    // in1 is the MSB of the index, in3 the LSB, so the mapping is identity.
    function automatic logic [2:0] idx_to_inputs(input logic [2:0] idx);
        return idx;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_timer.sv
// sweep_timer: loadable down-counter with a zero flag, shared by the
// SETTLE and SAMPLE phases of the sweeper.
//   clk       clock, rising edge
//   rst_n     synchronous active-low reset (count -> 0)
//   load      load load_val this cycle (wins over counting)
//   load_val  value to load
//   zero      count is zero
// The counter counts down by one per cycle and parks at zero.
module sweep_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives a 3-input combinational gate through all 8
// input combinations, samples its output after a settle period, assembles
// the 8-bit truth table and compares it with EXPECTED_TT.
//   clk       clock, rising edge
//   rst_n     synchronous active-low reset
//   start     sweep request, taken only in IDLE
//   abort     cancel a running sweep (wins over start)
//   dut_out   gate output, same clock domain
//   in1..in3  gate inputs, {in1,in2,in3} = combination index
//   busy      sweep in progress
//   done      one-cycle completion pulse
//   tt        captured table, tt[i] = out for index i
//   match     tt == EXPECTED_TT, valid from done until next start/abort
//   unstable  some combination gave disagreeing samples this sweep
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter logic [7:0] EXPECTED_TT   = TT_ONE_HOT_3,
    parameter int         SETTLE_CYCLES = 4,
    parameter int         NUM_SAMPLES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt,
    output logic       match,
    output logic       unstable
);

    localparam int CNT_MAX = (SETTLE_CYCLES > NUM_SAMPLES) ? SETTLE_CYCLES : NUM_SAMPLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    // The timer reads zero on the final cycle of a phase, so a phase of
    // length L is loaded with L-1.
    localparam logic [CW-1:0] SETTLE_LOAD = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [CW-1:0] SAMPLE_LOAD = CW'(NUM_SAMPLES - 1);

    state_t      state;
    logic [2:0]  idx;
    logic [2:0]  drive;
    logic        first;       // current SAMPLE cycle is the first of its combination
    logic        sample_bit;  // first sample of the current combination

    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_zero;

    assign {in1, in2, in3} = drive;

    // Timer is loaded on APPLY (settle length, or sample length when there
    // is no settle phase) and again on the last SETTLE cycle.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = SAMPLE_LOAD;
        case (state)
            APPLY: begin
                tmr_load = 1'b1;
                tmr_val  = (SETTLE_CYCLES == 0) ? SAMPLE_LOAD : SETTLE_LOAD;
            end
            SETTLE: begin
                if (tmr_zero) tmr_load = 1'b1;
            end
            default: ;
        endcase
    end

    sweep_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 3'd0;
            drive      <= 3'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tt         <= 8'h00;
            match      <= 1'b0;
            unstable   <= 1'b0;
            first      <= 1'b0;
            sample_bit <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && abort) begin
                state    <= IDLE;
                idx      <= 3'd0;
                drive    <= 3'd0;
                busy     <= 1'b0;
                tt       <= 8'h00;
                match    <= 1'b0;
                unstable <= 1'b0;
                first    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            idx      <= 3'd0;
                            drive    <= idx_to_inputs(3'd0);
                            tt       <= 8'h00;
                            match    <= 1'b0;
                            unstable <= 1'b0;
                            busy     <= 1'b1;
                            state    <= APPLY;
                        end
                    end
                    APPLY: begin
                        first <= 1'b1;
                        state <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
                    end
                    SETTLE: begin
                        if (tmr_zero) state <= SAMPLE;
                    end
                    SAMPLE: begin
                        first <= 1'b0;
                        if (first) begin
                            sample_bit <= dut_out;
                        end else if (dut_out != sample_bit) begin
                            unstable <= 1'b1;
                        end
                        if (tmr_zero) begin
                            // With a single sample the first one is also the last.
                            tt[idx] <= first ? dut_out : sample_bit;
                            if (idx == 3'd7) begin
                                state <= DONE;
                            end else begin
                                idx   <= idx + 3'd1;
                                drive <= idx_to_inputs(idx + 3'd1);
                                state <= APPLY;
                            end
                        end
                    end
                    DONE: begin
                        // Results and the done pulse appear together on exit.
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        match <= (tt == EXPECTED_TT);
                        drive <= 3'd0;
                        idx   <= 3'd0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper. A gate model drives dut_out from
// a truth-table variable, with an optional single-cycle inversion. Each
// sweep pushes its expected result; a monitor pops on every done pulse.
module tb_truth_table_sweeper;
    import tt_sweep_pkg::*;

    localparam int S    = 4;
    localparam int N    = 2;
    localparam int COMB = 1 + S + N;          // cycles per combination
    localparam int LAT  = 8 * COMB + 1;       // accept edge -> done
    localparam int LAT0 = 8 * (1 + 0 + N) + 1; // no-settle build

    typedef struct {
        logic [7:0] tt;
        logic       match;
        logic       unstable;
        int         cyc;
    } exp_t;

    exp_t q[$];
    exp_t q0[$];
    exp_t e;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, abort = 1'b0, start0 = 1'b0;
    logic [7:0] gate_tt = 8'h16, gate_tt0 = 8'h16;
    int   g_cyc = -1;
    logic dut_out, dut_out0;

    logic in1, in2, in3, busy, done, match, unstable;
    logic [7:0] tt;
    logic a1, a2, a3, busy0, done0, match0, unstable0;
    logic [7:0] tt0;

    int  trk_t0 = 0;
    logic trk = 1'b0;
    int  mon_m;
    int  t0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign dut_out  = gate_tt[{in1, in2, in3}] ^ (cyc == g_cyc);
    assign dut_out0 = gate_tt0[{a1, a2, a3}];

    truth_table_sweeper #(.EXPECTED_TT(8'h16), .SETTLE_CYCLES(S), .NUM_SAMPLES(N)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_out(dut_out),
        .in1(in1), .in2(in2), .in3(in3), .busy(busy), .done(done), .tt(tt),
        .match(match), .unstable(unstable)
    );

    truth_table_sweeper #(.EXPECTED_TT(8'h16), .SETTLE_CYCLES(0), .NUM_SAMPLES(N)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(1'b0), .dut_out(dut_out0),
        .in1(a1), .in2(a2), .in3(a3), .busy(busy0), .done(done0), .tt(tt0),
        .match(match0), .unstable(unstable0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: per-cycle input/busy sequence while tracking, and scoreboard pops on done.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (trk) begin
                mon_m = cyc - trk_t0;
                if (mon_m >= 0 && mon_m < 8 * COMB)
                    chk("inputs", 32'({in1, in2, in3}), 32'(mon_m / COMB));
                if (mon_m >= 0 && mon_m <= 8 * COMB)
                    chk("busy", 32'(busy), 32'd1);
            end
            if (done) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("tt", 32'(tt), 32'(e.tt));
                    chk("match", 32'(match), 32'(e.match));
                    chk("unstable", 32'(unstable), 32'(e.unstable));
                    chk("inputs_after_done", 32'({in1, in2, in3}), 32'd0);
                    chk("busy_after_done", 32'(busy), 32'd0);
                end
            end
            if (done0) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done0 actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    e = q0.pop_front();
                    chk("done0_cycle", 32'(cyc), 32'(e.cyc));
                    chk("tt0", 32'(tt0), 32'(e.tt));
                    chk("match0", 32'(match0), 32'(e.match));
                end
            end
        end
    end

    // Start one sweep; gk<0 means no glitch, else invert sample gj of combination gk.
    task automatic run_sweep(input logic [7:0] gtt, input int gk, input int gj, input bit push);
        exp_t x;
        @(negedge clk);
        gate_tt = gtt;
        start   = 1'b1;
        t0      = cyc + 1;
        g_cyc   = (gk >= 0) ? t0 + COMB * gk + 1 + S + gj : -1;
        trk_t0  = t0;
        trk     = 1'b1;
        x.tt    = gtt;
        if (gk >= 0 && gj == 0) x.tt[gk] = ~x.tt[gk];
        x.match    = (x.tt == 8'h16);
        x.unstable = (gk >= 0);
        x.cyc      = t0 + LAT;
        if (push) q.push_back(x);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_quiet(input int bound);
        int n = 0;
        while ((q.size() != 0 || q0.size() != 0 || busy || busy0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= bound) begin
            errors++;
            $display("FAIL timeout actual=%0d pending required=0", q.size() + q0.size());
        end
        trk = 1'b0;
    endtask

    task automatic chk_idle_zero(input string name);
        chk({name, "_in"}, 32'({in1, in2, in3}), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_tt"}, 32'(tt), 32'd0);
        chk({name, "_match"}, 32'(match), 32'd0);
        chk({name, "_unstable"}, 32'(unstable), 32'd0);
    endtask

    initial begin
        logic [7:0] r;
        exp_t x;
        repeat (2) @(negedge clk);
        chk_idle_zero("reset");
        chk("reset_busy0", 32'(busy0), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed: ideal gate, extra minterm, glitch on second sample of idx 3.
        run_sweep(8'h16, -1, 0, 1'b1); wait_quiet(200);
        run_sweep(8'h17, -1, 0, 1'b1); wait_quiet(200);
        run_sweep(8'h16, 3, 1, 1'b1);  wait_quiet(200);

        // Results hold after done; abort in IDLE changes nothing.
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("hold_tt", 32'(tt), 32'h16);
        chk("hold_unstable", 32'(unstable), 32'd1);
        chk("hold_match", 32'(match), 32'd1);

        // Randomized gates and glitches.
        for (int i = 0; i < 6; i++) begin
            r = 8'($urandom);
            if (i == 0) r = 8'h16;
            if ($urandom_range(0, 2) == 0)
                run_sweep(r, -1, 0, 1'b1);
            else
                run_sweep(r, int'($urandom_range(0, 7)), int'($urandom_range(0, N - 1)), 1'b1);
            wait_quiet(200);
        end

        // Abort 20 cycles into a sweep.
        run_sweep(8'h16, -1, 0, 1'b0);
        repeat (19) @(negedge clk);
        abort = 1'b1;
        trk   = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        chk_idle_zero("abort");
        repeat (70) @(negedge clk);
        run_sweep(8'h16, -1, 0, 1'b1); wait_quiet(200);

        // start held high across two sweeps: next accept is one cycle after done.
        @(negedge clk);
        gate_tt = 8'h16; g_cyc = -1;
        start = 1'b1;
        t0 = cyc + 1;
        trk_t0 = t0; trk = 1'b1;
        x.tt = 8'h16; x.match = 1'b1; x.unstable = 1'b0;
        x.cyc = t0 + LAT;             q.push_back(x);
        x.cyc = t0 + LAT + 1 + LAT;   q.push_back(x);
        repeat (LAT + 1) @(negedge clk);
        trk_t0 = t0 + LAT + 1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_quiet(300);

        // Reset pulse mid-SETTLE.
        run_sweep(8'h16, -1, 0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        trk   = 1'b0;
        @(negedge clk);
        chk_idle_zero("rst_mid");
        rst_n = 1'b1;
        repeat (70) @(negedge clk);

        // No-settle build.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            gate_tt0 = (i == 0) ? 8'h16 : 8'($urandom);
            start0 = 1'b1;
            x.tt = gate_tt0; x.match = (gate_tt0 == 8'h16); x.unstable = 1'b0;
            x.cyc = cyc + 1 + LAT0;
            q0.push_back(x);
            @(negedge clk);
            start0 = 1'b0;
            wait_quiet(100);
            chk("unstable0", 32'(unstable0), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
